// File: rtl/fhg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fhg_pkg
// Purpose  : Shared constants and write-FSM state type for the TX packet FIFO.
// Revision : 1.0
// ============================================================================
package fhg_pkg;

  localparam int DATA_WIDTH      = 1024;
  localparam int KEEP_WIDTH      = 128;
  localparam int MAX_FRAME_BYTES = 9216;

  typedef enum logic [0:0] {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_e;

endpackage : fhg_pkg
`default_nettype wire

// File: rtl/fhg_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : fhg_sdp_ram
// Purpose  : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
module fhg_sdp_ram #(
  parameter int WIDTH = 1153,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fhg_sdp_ram
`default_nettype wire

// File: rtl/casper_tx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : casper_tx_pkt_fifo
// Purpose  : Store-and-forward frame FIFO; releases only complete good frames.
// Revision : 1.0
// ============================================================================
module casper_tx_pkt_fifo #(
  parameter int DATA_WIDTH    = fhg_pkg::DATA_WIDTH,
  parameter int KEEP_WIDTH    = fhg_pkg::KEEP_WIDTH,
  parameter int DEPTH         = 128,
  parameter int MAX_PKT_WORDS = fhg_pkg::MAX_FRAME_BYTES / (fhg_pkg::DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  drop_pulse,
  output logic [31:0]           drop_cnt,
  output logic [7:0]            pkt_avail
);

  import fhg_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam int RW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] wcnt_q, wcnt_d;
  wr_state_e     state_q, state_d;
  logic          ram_we, commit, drop, full;

  logic          ram_vld_q, pf_vld_q, out_vld_q;
  logic [RW-1:0] ram_rdata, pf_q, out_q;
  logic          rd_issue, pop;
  logic [1:0]    occ;
  logic [31:0]   drop_cnt_q;
  logic          drop_pulse_q;
  logic [7:0]    pkt_avail_q;

  // Full is judged against rd_ptr before this cycle's read, deliberately conservative.
  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wcnt_d      = wcnt_q;
    state_d     = state_q;
    ram_we      = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        WRITE: begin
          if (!full && (wcnt_q < CW'(MAX_PKT_WORDS))) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            wcnt_d   = wcnt_q + 1'b1;
            if (s_axis_tlast) begin
              wcnt_d = '0;
              if (s_axis_tuser) begin
                wr_ptr_d = wr_commit_q;
                drop     = 1'b1;
              end else begin
                wr_commit_d = wr_ptr_q + 1'b1;
                commit      = 1'b1;
              end
            end
          end else begin
            wr_ptr_d = wr_commit_q;
            if (s_axis_tlast) begin
              drop   = 1'b1;
              wcnt_d = '0;
            end else begin
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            drop    = 1'b1;
            wcnt_d  = '0;
            state_d = WRITE;
          end
        end
        default: state_d = WRITE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      wcnt_q       <= '0;
      state_q      <= WRITE;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      wcnt_q       <= wcnt_d;
      state_q      <= state_d;
      drop_pulse_q <= drop;
      drop_cnt_q   <= drop_cnt_q + {31'd0, drop};
    end
  end

  fhg_sdp_ram #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Words in flight or buffered after this cycle's pop; capped at two (output + prefetch).
  assign pop      = out_vld_q && m_axis_tready;
  assign occ      = {1'b0, ram_vld_q} + {1'b0, pf_vld_q} + {1'b0, out_vld_q && !m_axis_tready};
  assign rd_issue = (rd_ptr_q != wr_commit_q) && (occ < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      pf_vld_q    <= 1'b0;
      pf_q        <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      pkt_avail_q <= '0;
    end else begin
      ram_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (!out_vld_q || pop) begin
        if (pf_vld_q) begin
          out_q     <= pf_q;
          out_vld_q <= 1'b1;
          pf_vld_q  <= ram_vld_q;
          if (ram_vld_q) begin
            pf_q <= ram_rdata;
          end
        end else if (ram_vld_q) begin
          out_q     <= ram_rdata;
          out_vld_q <= 1'b1;
        end else begin
          out_vld_q <= 1'b0;
        end
      end else if (ram_vld_q) begin
        pf_q     <= ram_rdata;
        pf_vld_q <= 1'b1;
      end
      case ({commit, pop && out_q[RW-1]})
        2'b10:   pkt_avail_q <= pkt_avail_q + 8'd1;
        2'b01:   pkt_avail_q <= pkt_avail_q - 8'd1;
        default: pkt_avail_q <= pkt_avail_q;
      endcase
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_q[RW-1];
  assign m_axis_tkeep  = out_q[RW-2 -: KEEP_WIDTH];
  assign m_axis_tdata  = out_q[DATA_WIDTH-1:0];
  assign drop_pulse    = drop_pulse_q;
  assign drop_cnt      = drop_cnt_q;
  assign pkt_avail     = pkt_avail_q;

endmodule : casper_tx_pkt_fifo
`default_nettype wire

// File: tb/tb_casper_tx_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_casper_tx_pkt_fifo
// Purpose  : Directed scoreboard bench for the TX store-and-forward FIFO.
// Revision : 1.0
// ============================================================================
module tb_casper_tx_pkt_fifo;

  localparam int DW = 1024;
  localparam int KW = 128;
  localparam int RW = DW + KW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          drop_pulse;
  logic [31:0]   drop_cnt;
  logic [7:0]    pkt_avail;

  casper_tx_pkt_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .drop_pulse    (drop_pulse),
    .drop_cnt      (drop_cnt),
    .pkt_avail     (pkt_avail)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            exp_drops = 0;
  int            pulse_seen = 0;
  int            words_out = 0;
  logic [RW-1:0] sb_q[$];

  function automatic logic [DW-1:0] mk(input int f, input int w);
    logic [DW-1:0] d;
    d = '0;
    d[31:0] = w;
    d[63:32] = f;
    d[DW-1 -: 32] = 32'(f * 1000 + w);
    return d;
  endfunction

  function automatic logic [KW-1:0] mkkeep(input int f, input logic lst);
    logic [KW-1:0] k;
    k = '1;
    if (!lst || f == 0) return k;
    return k >> ((f % 100) + 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic drive_word(input int f, input int w, input int n, input logic user, input logic pass);
    logic lst;
    lst = (w == n);
    s_axis_tdata  = mk(f, w);
    s_axis_tkeep  = mkkeep(f, lst);
    s_axis_tlast  = lst;
    s_axis_tuser  = lst ? user : 1'b0;
    s_axis_tvalid = 1'b1;
    if (pass) sb_q.push_back({lst, s_axis_tkeep, s_axis_tdata});
  endtask

  task automatic send_frame(input int f, input int n, input logic user, input logic pass);
    for (int w = 1; w <= n; w++) begin
      drive_word(f, w, n, user, pass);
      tick();
    end
    idle();
    if (pass) begin
      check("no_drop_pulse", {63'd0, drop_pulse}, 64'd0);
    end else begin
      check("drop_pulse_at_tlast", {63'd0, drop_pulse}, 64'd1);
      exp_drops++;
    end
  endtask

  // Called right after a frame's tlast edge with an idle output path.
  task automatic latency_check(input int f);
    check("lat_edge0_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    tick();
    check("lat_edge1_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    tick();
    check("lat_edge2_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    check("lat_first_data", m_axis_tdata[63:0], mk(f, 1) & 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && sb_q.size() != 0; i++) tick();
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    tick();
    tick();
    check("pkt_avail_zero", {56'd0, pkt_avail}, 64'd0);
    check("drop_cnt", {32'd0, drop_cnt}, 64'(exp_drops));
    check("drop_pulse_count", 64'(pulse_seen), 64'(exp_drops));
  endtask

  // Output monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic          prev_stall;
    logic [RW-1:0] prev_word;
    logic [RW-1:0] cur;
    logic [RW-1:0] exp;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (drop_pulse === 1'b1) pulse_seen++;
        if (prev_stall) begin
          total++;
          assert (m_axis_tvalid === 1'b1 && cur === prev_word) else begin
            bad++;
            $error("FAIL hold_stable observed=%0h/%0h expected=1/%0h", m_axis_tvalid, cur[63:0], prev_word[63:0]);
          end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          words_out++;
          total++;
          assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_word observed=%0h expected=none", cur[63:0]);
          end
          if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            total++;
            assert (cur === exp) else begin
              bad++;
              $error("FAIL out_word observed=last%0h keep%0h data%0h expected=last%0h keep%0h data%0h",
                     cur[RW-1], cur[RW-2 -: 16], cur[63:0], exp[RW-1], exp[RW-2 -: 16], exp[63:0]);
            end
          end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        prev_word  = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata_zero", {63'd0, |m_axis_tdata}, 64'd0);
    check("rst_drop_cnt", {32'd0, drop_cnt}, 64'd0);
    check("rst_pkt_avail", {56'd0, pkt_avail}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: single 64-word frame, latency 2 edges after tlast
    send_frame(0, 64, 1'b0, 1'b1);
    latency_check(0);
    drain();

    // 2: errored frame then clean frame
    send_frame(2, 10, 1'b1, 1'b0);
    send_frame(3, 10, 1'b0, 1'b1);
    drain();

    // 3: oversize frame then short frame
    send_frame(4, 73, 1'b0, 1'b0);
    send_frame(5, 5, 1'b0, 1'b1);
    drain();

    // 4: overflow with output stalled
    m_axis_tready = 1'b0;
    send_frame(6, 64, 1'b0, 1'b1);
    send_frame(7, 64, 1'b0, 1'b1);
    send_frame(8, 64, 1'b0, 1'b0);
    tick();
    check("ovf_pkt_avail", {56'd0, pkt_avail}, 64'd2);
    check("ovf_drop_cnt", {32'd0, drop_cnt}, 64'(exp_drops));
    w0 = words_out;
    m_axis_tready = 1'b1;
    drain();
    check("ovf_words_out", 64'(words_out - w0), 64'd128);

    // 5: ready toggling every cycle
    fork
      begin
        repeat (300) begin
          @(posedge clk);
          #2;
          m_axis_tready = ~m_axis_tready;
        end
      end
    join_none
    send_frame(9, 64, 1'b0, 1'b1);
    wait fork;
    m_axis_tready = 1'b1;
    drain();

    // 6: reset mid-frame while streaming
    send_frame(60, 64, 1'b0, 1'b1);
    for (int w = 1; w <= 30; w++) begin
      drive_word(61, w, 40, 1'b0, 1'b0);
      if (w < 30) tick();
    end
    check("stream_before_rst", {63'd0, m_axis_tvalid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("async_rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("async_rst_tdata", {63'd0, |m_axis_tdata}, 64'd0);
    check("async_rst_tkeep", {63'd0, |m_axis_tkeep}, 64'd0);
    check("async_rst_pkt_avail", {56'd0, pkt_avail}, 64'd0);
    check("async_rst_drop_cnt", {32'd0, drop_cnt}, 64'd0);
    sb_q.delete();
    exp_drops  = 0;
    pulse_seen = 0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_frame(62, 4, 1'b0, 1'b1);
    latency_check(62);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_casper_tx_pkt_fifo
`default_nettype wire

// File: doc/casper_tx_pkt_fifo.md
Name: casper_tx_pkt_fifo

Overview:
Store-and-forward packet FIFO on the 400G TX path. It sits directly upstream of the 400G AXIS adapter, between the CASPER 1024-bit AXI-stream TX source and the adapter's casper_tx input.
- The CASPER source has no backpressure, so this block absorbs the stream and buffers whole frames.
- It releases only complete, error-free frames, which guarantees the DCMAC never sees a mid-packet underrun.
- It drops errored, oversize or overflowing frames and counts them.

Parameters:
DATA_WIDTH, 1024, stream data width in bits
KEEP_WIDTH, 128, byte-enable width (DATA_WIDTH/8)
DEPTH, 128, buffer depth in words (power of 2, at least MAX_PKT_WORDS)
MAX_PKT_WORDS, 72, maximum frame length in words (9216 B); longer frames are dropped

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous reset, active-high
s_axis_tdata  in  DATA_WIDTH  input word
s_axis_tkeep  in  KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  input word valid (no tready exists; input is always accepted)
s_axis_tlast  in  1  last word of frame
s_axis_tuser  in  1  frame error; sampled on the tlast word
m_axis_tdata  out  DATA_WIDTH  output word to the adapter
m_axis_tkeep  out  KEEP_WIDTH  byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  adapter ready
m_axis_tlast  out  1  last word of frame
drop_pulse  out  1  one-cycle pulse per dropped frame
drop_cnt  out  32  dropped-frame count, wraps
pkt_avail  out  8  committed frames not yet fully read

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers, counters, pkt_avail, drop_cnt, drop_pulse and m_axis_tvalid/tlast/tdata/tkeep all clear to 0.
  - Write FSM goes to WRITE.
  - Any partially buffered or partially read frame is lost.
- Storage:
  - RAM word = {tlast, tkeep, tdata}.
  - Pointers wr_ptr, wr_commit and rd_ptr are each log2(DEPTH)+1 bits wide.
  - Full condition: wr_ptr - rd_ptr == DEPTH.
- Write FSM, states WRITE and DROP; word counter wcnt starts at 0 at each frame start.
  - WRITE, valid word, not full, wcnt < MAX_PKT_WORDS:
    - Write the word at wr_ptr, then wr_ptr++ and wcnt++.
    - If tlast && !tuser: wr_commit <= wr_ptr+1, pkt_avail++, wcnt <= 0.
    - If tlast && tuser: rewind wr_ptr to wr_commit, drop, wcnt <= 0.
  - WRITE, valid word while full, or wcnt == MAX_PKT_WORDS:
    - Rewind wr_ptr to wr_commit and discard the word.
    - If that word has tlast: record the drop now and stay in WRITE.
    - Otherwise: go to DROP.
  - DROP: discard every valid word. On tlast, record the drop, set wcnt <= 0 and return to WRITE.
  - Recording a drop means: drop_pulse=1 for one cycle and drop_cnt++. This happens exactly once per frame.
- Read side:
  - Only committed words are read (rd_ptr != wr_commit).
  - RAM read latency is 1 cycle. The output register plus one prefetch stage sustains 1 word/cycle while m_axis_tready=1.
  - m_axis_* hold stable while tvalid && !tready.
  - Latency: for a frame whose tlast is written at edge N, the first output word has m_axis_tvalid=1 after edge N+2 (provided output is idle and no frames are ahead).
  - When a tlast word handshakes, pkt_avail decrements.
  - If a commit and a tlast handshake occur in the same cycle, pkt_avail is unchanged.
- Simultaneous read/write: full is evaluated against rd_ptr before the current cycle's read, which is conservative.
- Frame order is preserved. tkeep passes through unmodified.

Decomposition:
- Shared package fhg_pkg holds:
  - Constants DATA_WIDTH=1024, KEEP_WIDTH=128, MAX_FRAME_BYTES=9216.
  - The write-FSM state enum {WRITE, DROP}.
- One natural sub-module: fhg_sdp_ram, a simple dual-port RAM with parameters WIDTH and DEPTH and a registered (1-cycle) read. It is instantiated with WIDTH = DATA_WIDTH+KEEP_WIDTH+1.

Test Plan:
1. Single 8192 B frame:
   - Stimulus: 64 consecutive words with tdata=1..64 and tkeep all-ones; tlast on word 64; m_axis_tready=1.
   - Response: 64 identical words out; first m_axis_tvalid 2 cycles after tlast is written; m_axis_tlast only on word 64; drop_cnt=0.
2. Errored frame:
   - Stimulus: a 10-word frame with tuser=1 on tlast, then a clean 10-word frame.
   - Response: only the clean frame is output; drop_pulse fires once; drop_cnt=1.
3. Oversize frame:
   - Stimulus: 73 words with tlast on word 73 (MAX_PKT_WORDS=72), then a 5-word frame.
   - Response: no output from the 73-word frame; drop_cnt=1, pulsed at word 73; the 5-word frame passes intact.
4. Overflow:
   - Stimulus: m_axis_tready=0; send three 64-word frames; then set tready=1.
   - Response: pkt_avail=2; third frame dropped (drop_cnt=1); exactly 128 words out, in order.
5. Backpressure:
   - Stimulus: m_axis_tready toggles every cycle during a 64-word frame.
   - Response: data is held stable while stalled; all 64 words arrive in order; pkt_avail returns to 0.
6. Reset mid-frame:
   - Stimulus: assert rst during word 30 of an input frame while output is streaming.
   - Response: all outputs go to 0 before the next edge; after release, a new 4-word frame passes with first tvalid 2 cycles after its tlast.
